// File: rtl/lcd_bus_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_bus_scheduler
//
// Owns an 8-bit HD44780-style LCD bus (RS, E, DB[7:0]) and shares it between
// N_REQ byte writers. After reset it waits T_POWERUP cycles and then plays a
// fixed four-byte init sequence. After that it accepts one byte at a time,
// choosing among the requesters round-robin, and generates the bus timing for
// each byte: setup, E pulse, hold, then the execution wait.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N_REQ]    requester i has a byte pending (held until accepted)
//   req_rs     [N_REQ]    RS for requester i's byte (0 = command, 1 = data)
//   req_data   [8*N_REQ]  byte for requester i in bits [8i+7:8i]
//   req_ready  [N_REQ]    one-hot accept (combinational)
//   grant_id   [3]        index of the requester last accepted
//   init_done             high once the init sequence has completed
//   busy                  high whenever the scheduler is not in IDLE
//   lcd_rs, lcd_e, lcd_db LCD bus, all registered
//
// Handshake: a byte moves on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever raised in IDLE after
// init, for at most one requester, and depends on req_valid in the same
// cycle. A requester may drop req_valid before it is accepted; the byte is
// then simply never sent.
// ---------------------------------------------------------------------------
module lcd_bus_scheduler #(
    parameter int N_REQ       = 3,
    parameter int T_POWERUP   = 750000,
    parameter int T_AS        = 4,
    parameter int T_PW        = 25,
    parameter int T_H         = 4,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_rs,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [2:0]         grant_id,
    output logic               init_done,
    output logic               busy,
    output logic               lcd_rs,
    output logic               lcd_e,
    output logic [7:0]         lcd_db
);

    localparam int CNT_MAX = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    init_idx;
    logic [2:0]    ptr;

    // Requester vectors padded to the full 8-slot width so a 3-bit index is
    // always in range regardless of N_REQ.
    logic [7:0]    valid_pad;
    logic [7:0]    rs_pad;
    logic [63:0]   data_pad;

    logic          sel_found;
    logic [2:0]    sel;
    logic [3:0]    cand;
    logic          long_wait;
    logic [CW-1:0] wait_last;

    assign valid_pad = 8'(req_valid);
    assign rs_pad    = 8'(req_rs);
    assign data_pad  = 64'(req_data);

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h3C;  // 8-bit bus, 2 lines
            2'd1:    return 8'h01;  // clear display
            2'd2:    return 8'h06;  // entry mode: increment
            default: return 8'h0C;  // display on, cursor off
        endcase
    endfunction

    // Round-robin search starting one past the last grant, wrapping at N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel       = 3'd0;
        cand      = 4'd0;
        req_ready = '0;
        if (state == S_IDLE && init_done) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = {1'b0, ptr} + 4'(k);
                if (cand >= 4'(N_REQ)) begin
                    cand = cand - 4'(N_REQ);
                end
                if (!sel_found && valid_pad[cand[2:0]]) begin
                    sel_found = 1'b1;
                    sel       = cand[2:0];
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = sel_found && (sel == 3'(i));
        end
    end

    // Clear and return-home (0x01..0x03 as commands) need the long wait.
    assign long_wait = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02 || lcd_db == 8'h03);
    assign wait_last = long_wait ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_POWERUP;
            cnt       <= '0;
            init_idx  <= 2'd0;
            ptr       <= 3'(N_REQ - 1);
            grant_id  <= 3'd0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_db    <= 8'h00;
        end else begin
            case (state)
                S_POWERUP: begin
                    if (cnt == CW'(T_POWERUP - 1)) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        init_idx <= 2'd0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOAD: begin
                    lcd_rs <= 1'b0;
                    lcd_db <= init_rom(init_idx);
                    state  <= S_SETUP;
                    cnt    <= '0;
                end
                S_IDLE: begin
                    if (!init_done) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end else if (sel_found) begin
                        lcd_rs   <= rs_pad[sel];
                        lcd_db   <= data_pad[{sel, 3'b000} +: 8];
                        grant_id <= sel;
                        ptr      <= sel;
                        state    <= S_SETUP;
                        busy     <= 1'b1;
                        cnt      <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt == CW'(T_AS - 1)) begin
                        lcd_e <= 1'b1;
                        state <= S_PULSE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == CW'(T_PW - 1)) begin
                        lcd_e <= 1'b0;
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(T_H - 1)) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == wait_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (!init_done) begin
                            init_idx <= init_idx + 2'd1;
                            if (init_idx == 2'd3) begin
                                init_done <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_POWERUP;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    lcd_e <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_scheduler
//
// Directed bench for lcd_bus_scheduler with short timing parameters.
// One initial block walks through: reset values, the power-up/init sequence,
// three-way round-robin, a single requester sending long and short commands,
// a dropped request, and a reset while E is high followed by the rerun init
// with a request already pending. A per-cycle monitor checks that req_ready
// is one-hot-or-zero and gated, and that RS/DB are stable around the E pulse.
// ---------------------------------------------------------------------------
module tb_lcd_bus_scheduler;

    localparam int N_REQ       = 3;
    localparam int T_POWERUP   = 20;
    localparam int T_AS        = 2;
    localparam int T_PW        = 3;
    localparam int T_H         = 2;
    localparam int T_EXEC      = 5;
    localparam int T_EXEC_LONG = 12;

    localparam int S_E    = 0;
    localparam int S_BUSY = 1;
    localparam int S_RDY  = 2;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_rs;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [2:0]         grant_id;
    logic               init_done;
    logic               busy;
    logic               lcd_rs;
    logic               lcd_e;
    logic [7:0]         lcd_db;

    int checks = 0;
    int errors = 0;

    lcd_bus_scheduler #(
        .N_REQ       (N_REQ),
        .T_POWERUP   (T_POWERUP),
        .T_AS        (T_AS),
        .T_PW        (T_PW),
        .T_H         (T_H),
        .T_EXEC      (T_EXEC),
        .T_EXEC_LONG (T_EXEC_LONG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            S_E:     return lcd_e;
            S_BUSY:  return busy;
            S_RDY:   return |req_ready;
            default: return 1'bx;
        endcase
    endfunction

    // Steps negedge by negedge until the selected signal equals v; n is the
    // number of negedges waited. Reaching the bound shows up as a failed check.
    task automatic wait_for(input string tag, input int s, input logic v, input int limit,
                            output int n);
        n = 0;
        while (sig(s) !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 32'(sig(s)), 32'(v));
    endtask

    // ---------------- per-cycle monitor ----------------
    int         cyc       = 0;
    int         last_chg  = 0;
    int         hold_left = 0;
    logic       prev_rst  = 1'b0;
    logic       prev_e    = 1'b0;
    logic [8:0] prev_bus  = '0;
    logic       bus_chg;

    always @(negedge clk) begin
        cyc++;
        check("mon_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        check("mon_ready_gated", 32'((|req_ready) && (busy || !init_done)), 32'd0);
        if (rst_n && prev_rst) begin
            bus_chg = ({lcd_rs, lcd_db} !== prev_bus);
            check("mon_bus_stable", 32'(bus_chg && (lcd_e || prev_e || hold_left > 0)), 32'd0);
            if (lcd_e && !prev_e) begin
                check("mon_setup_time", 32'((cyc - last_chg) >= T_AS), 32'd1);
            end
            if (bus_chg) last_chg = cyc;
            if (prev_e && !lcd_e) hold_left = T_H - 1;
            else if (hold_left > 0) hold_left--;
        end else begin
            hold_left = 0;
            last_chg  = cyc;
        end
        prev_rst = rst_n;
        prev_e   = lcd_e;
        prev_bus = {lcd_rs, lcd_db};
    end

    // ---------------- directed sequence ----------------
    logic [7:0] rom [4] = '{8'h3C, 8'h01, 8'h06, 8'h0C};
    logic [7:0] rr_byte [3] = '{8'h42, 8'h45, 8'h44};  // 'B', 'E', 'D'

    initial begin
        int n;
        int n_e;
        int gi;

        rst_n     = 1'b0;
        req_valid = '0;
        req_rs    = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_lcd_e", 32'(lcd_e), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_db", 32'(lcd_db), 32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // 1. Power-up wait and init sequence, no requests
        rst_n = 1'b1;
        wait_for("t1_first_e", S_E, 1'b1, 100, n);
        check("t1_powerup_to_e", 32'(n), 32'd23);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                wait_for("t1_e_rise", S_E, 1'b1, 50, n);
                check("t1_idle_to_e", 32'(n), 32'd4);
            end
            check("t1_db", 32'(lcd_db), 32'(rom[b]));
            check("t1_rs", 32'(lcd_rs), 32'd0);
            wait_for("t1_e_fall", S_E, 1'b0, 50, n);
            check("t1_pulse_width", 32'(n), 32'd3);
            wait_for("t1_idle", S_BUSY, 1'b0, 50, n);
            check("t1_fall_to_idle", 32'(n), (b == 1) ? 32'd14 : 32'd7);
            check("t1_init_done", 32'(init_done), 32'(b == 3));
        end

        // 2. All three requesters, data bytes, served round-robin
        req_rs    = 3'b111;
        req_data  = {rr_byte[2], rr_byte[1], rr_byte[0]};
        req_valid = 3'b111;
        #1;
        n_e = 0;
        for (int g = 0; g < 5; g++) begin
            gi = g % 3;
            wait_for("t2_ready", S_RDY, 1'b1, 40, n);
            if (g > 0) check("t2_accept_interval", 32'(1 + n_e + n), 32'd13);
            check("t2_ready_vec", 32'(req_ready), 32'(1 << gi));
            @(negedge clk);
            check("t2_grant_id", 32'(grant_id), 32'(gi));
            check("t2_db", 32'(lcd_db), 32'(rr_byte[gi]));
            check("t2_rs", 32'(lcd_rs), 32'd1);
            check("t2_busy", 32'(busy), 32'd1);
            wait_for("t2_e_rise", S_E, 1'b1, 40, n_e);
            check("t2_accept_to_e", 32'(n_e), 32'd2);
        end
        wait_for("t2_ready_last", S_RDY, 1'b1, 40, n);
        check("t2_accept_interval_last", 32'(1 + n_e + n), 32'd13);
        check("t2_ready_wrap", 32'(req_ready), 32'b100);

        // 3. Requester 2 alone: return-home command then a normal command
        req_valid = 3'b100;
        req_rs    = 3'b000;
        req_data  = {8'h02, 8'h00, 8'h00};
        #1;
        check("t3_ready_cmd02", 32'(req_ready), 32'b100);
        @(negedge clk);
        check("t3_grant_cmd02", 32'(grant_id), 32'd2);
        check("t3_db_cmd02", 32'(lcd_db), 32'h02);
        check("t3_rs_cmd02", 32'(lcd_rs), 32'd0);
        wait_for("t3_e_rise_02", S_E, 1'b1, 40, n);
        wait_for("t3_e_fall_02", S_E, 1'b0, 40, n);
        wait_for("t3_ready_02", S_RDY, 1'b1, 60, n);
        check("t3_long_wait", 32'(n), 32'(T_H + T_EXEC_LONG));

        req_data = {8'h80, 8'h00, 8'h00};
        #1;
        check("t3_ready_cmd80", 32'(req_ready), 32'b100);
        @(negedge clk);
        check("t3_grant_cmd80", 32'(grant_id), 32'd2);
        check("t3_db_cmd80", 32'(lcd_db), 32'h80);
        wait_for("t3_e_rise_80", S_E, 1'b1, 40, n);
        wait_for("t3_e_fall_80", S_E, 1'b0, 40, n);
        wait_for("t3_ready_80", S_RDY, 1'b1, 60, n);
        check("t3_short_wait", 32'(n), 32'(T_H + T_EXEC));

        // Request withdrawn before acceptance: nothing is driven
        req_valid = 3'b000;
        #1;
        check("t3_drop_ready", 32'(req_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("t3_drop_busy", 32'(busy), 32'd0);
        check("t3_drop_db", 32'(lcd_db), 32'h80);
        check("t3_drop_e", 32'(lcd_e), 32'd0);

        // 5. Reset while E is high, then 4. request pending through the rerun
        req_valid = 3'b010;
        req_rs    = 3'b010;
        req_data  = {8'h00, 8'h55, 8'h00};
        #1;
        check("t5_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        check("t5_grant", 32'(grant_id), 32'd1);
        wait_for("t5_e_rise", S_E, 1'b1, 40, n);
        rst_n = 1'b0;
        #1;
        check("t5_rst_lcd_e", 32'(lcd_e), 32'd0);
        check("t5_rst_lcd_db", 32'(lcd_db), 32'h00);
        check("t5_rst_init_done", 32'(init_done), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd1);
        check("t5_rst_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            check("t4_no_ready_in_init", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("t4_init_done_reached", 32'(init_done), 32'd1);
        check("t4_rerun_length", 32'(n), 32'd82);
        check("t4_first_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        check("t4_first_grant", 32'(grant_id), 32'd1);
        check("t4_first_db", 32'(lcd_db), 32'h55);
        check("t4_first_rs", 32'(lcd_rs), 32'd1);
        req_valid = 3'b000;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
